// File: rtl/sev_seg_pkg.sv
// Segment encoding shared by the seven-segment scan driver.
// Codes are active-low, bit 6 = g ... bit 0 = a.
package sev_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // In decimal mode anything above 9 is not a digit and stays dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble, input logic hex_mode);
        if (!hex_mode && (nibble > 4'd9)) begin
            return SEG_BLANK;
        end
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/sev_seg_prescale.sv
// Slot prescaler and digit index for the display scan; strobes are combinational from state.
// Free-running, no backpressure: one slot every CLK_DIV cycles, one frame every NUM_DIGITS slots.
module sev_seg_prescale #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 1,
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             slot_end,
    output logic             blank_win,
    output logic             frame_end
);

    localparam int                PCNT_W    = $clog2(CLK_DIV);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [PCNT_W-1:0] pcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (slot_end) begin
            pcnt <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign slot_end  = (pcnt == PCNT_LAST);
    assign blank_win = (pcnt < PCNT_W'(BLANK_CYC));
    assign frame_end = slot_end && (idx == IDX_LAST);

endmodule

// File: rtl/sev_seg_scan.sv
// Multiplexed seven-segment driver with frame-synchronous value updates and leading-zero blanking.
// Outputs registered, 1-cycle latency from scan state; load is always accepted (last load wins).
module sev_seg_scan
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int                    IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic [IDX_W-1:0] idx;
    logic             slot_end;
    logic             blank_win;
    logic             frame_end;

    sev_seg_prescale #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_DIV    (CLK_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .IDX_W      (IDX_W)
    ) u_prescale (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .slot_end  (slot_end),
        .blank_win (blank_win),
        .frame_end (frame_end)
    );

    assert property (@(posedge clk) disable iff (rst) frame_end |-> slot_end);

    logic [4*NUM_DIGITS-1:0] act_value;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    act_hex;
    logic                    act_lz;
    logic                    pend_vld;

    // Active contents only change on the frame boundary, so a frame is never mixed.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_value  <= '0;
            act_dp     <= '0;
            act_hex    <= 1'b0;
            act_lz     <= 1'b0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_vld   <= 1'b0;
        end else if (frame_end) begin
            act_hex  <= hex_mode;
            act_lz   <= lz_blank;
            pend_vld <= 1'b0;
            if (load) begin
                act_value <= value;
                act_dp    <= dp;
            end else if (pend_vld) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
            end
        end else if (load) begin
            pend_value <= value;
            pend_dp    <= dp;
            pend_vld   <= 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  seen_nz;

    always_comb begin
        lz_mask = '0;
        seen_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (act_value[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            lz_mask[i] = act_lz && !seen_nz;
        end
    end

    logic [NUM_DIGITS-1:0] sel;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  dp_on;
    logic [6:0]            code_low;

    always_comb begin
        sel       = '0;
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel[i]    = 1'b1;
                cur_nib   = act_value[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_blank = lz_mask[i];
            end
        end
        dp_on    = cur_dp && !cur_blank;
        code_low = cur_blank ? SEG_BLANK : seg_decode(cur_nib, act_hex);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_OFF;
            seg_dp     <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (blank_win) begin
                seg    <= SEG_OFF;
                seg_dp <= DP_OFF;
                an     <= AN_OFF;
            end else begin
                seg    <= SEG_ACTIVE_LOW ? code_low : ~code_low;
                seg_dp <= SEG_ACTIVE_LOW ? !dp_on : dp_on;
                an     <= AN_ACTIVE_LOW ? ~sel : sel;
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Bench for sev_seg_scan: 4 digits, 4-cycle slots, 1 blank cycle, active-low pins.
module tb_sev_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        load = 1'b0;
    logic        hex_mode = 1'b0;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    sev_seg_scan #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (4),
        .BLANK_CYC      (1),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .hex_mode   (hex_mode),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_code(input logic [3:0] n, input logic hex);
        if (n > 4'd9 && !hex) return 7'b1111111;
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic int lit_digit(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Reference model: time since reset gives slot and digit; contents follow the load rules.
    int          m_cnt;
    logic [15:0] m_act_val, m_pend_val;
    logic [3:0]  m_act_dp, m_pend_dp;
    logic        m_act_hex, m_act_lz, m_pend_vld;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    logic [3:0]  e_an;

    always @(posedge clk) begin
        int slot, dig;
        logic lz_off;
        if (rst) begin
            m_cnt = 0;
            m_act_val = '0; m_act_dp = '0; m_act_hex = 1'b0; m_act_lz = 1'b0;
            m_pend_val = '0; m_pend_dp = '0; m_pend_vld = 1'b0;
            e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'b1111; e_fd = 1'b0;
        end else begin
            slot = m_cnt % 4;
            dig  = (m_cnt / 4) % 4;
            if (slot == 0) begin
                e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'b1111;
            end else begin
                lz_off = m_act_lz && dig != 0 && (m_act_val >> (4 * dig)) == 16'd0;
                e_an  = ~(4'b0001 << dig);
                e_seg = lz_off ? 7'b1111111 : ref_code(4'(m_act_val >> (4 * dig)), m_act_hex);
                e_dp  = !(m_act_dp[dig] && !lz_off);
            end
            e_fd = (m_cnt % 16) == 15;
            if ((m_cnt % 16) == 15) begin
                if (load) begin
                    m_act_val = value; m_act_dp = dp;
                end else if (m_pend_vld) begin
                    m_act_val = m_pend_val; m_act_dp = m_pend_dp;
                end
                m_pend_vld = 1'b0;
                m_act_hex = hex_mode;
                m_act_lz  = lz_blank;
            end else if (load) begin
                m_pend_val = value; m_pend_dp = dp; m_pend_vld = 1'b1;
            end
            m_cnt++;
        end
    end

    task automatic wait_frame();
        checks++;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        errors++;
        $display("FAIL frame_wait: frame_done=0 after 40 cycles, required a pulse");
    endtask

    task automatic test_reset();
        logic [3:0] want_an;
        int lit_cnt = 0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (seg !== 7'b1111111 || seg_dp !== 1'b1 || an !== 4'b1111 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: seg=%b dp=%b an=%b fd=%b, required 1111111 1 1111 0",
                         seg, seg_dp, an, frame_done);
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            want_an = ((c - 1) % 4 == 0) ? 4'b1111 : ~(4'b0001 << (((c - 1) / 4) % 4));
            checks++;
            if (an !== want_an || frame_done !== (c == 16)) begin
                errors++;
                $display("FAIL reset_scan c=%0d: an=%b fd=%b, required an=%b fd=%0d",
                         c, an, frame_done, want_an, c == 16);
            end
            if (c <= 16 && an == 4'b1110) lit_cnt++;
        end
        checks++;
        if (lit_cnt != 3) begin
            errors++;
            $display("FAIL reset_lit_len: digit0 lit %0d cycles, required 3", lit_cnt);
        end
    endtask

    task automatic test_decimal();
        logic [6:0] want [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        int d;
        hex_mode = 1'b0; lz_blank = 1'b0;
        value = 16'h1234; dp = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame();
        repeat (16) begin
            @(negedge clk);
            d = lit_digit(an);
            if (d >= 0) begin
                checks++;
                if (seg !== want[d] || seg_dp !== 1'b1) begin
                    errors++;
                    $display("FAIL decimal digit%0d: seg=%b dp=%b, required seg=%b dp=1", d, seg, seg_dp, want[d]);
                end
            end
        end
    endtask

    task automatic test_hex_vs_decimal();
        logic [6:0] want_hex [4] = '{7'b0001110, 7'b0001000, 7'b1000000, 7'b1000000};
        logic [6:0] want_dec [4] = '{7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000};
        int d;
        hex_mode = 1'b1;
        value = 16'h00AF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame();
        repeat (16) begin
            @(negedge clk);
            d = lit_digit(an);
            if (d >= 0) begin
                checks++;
                if (seg !== want_hex[d]) begin
                    errors++;
                    $display("FAIL hex_mode digit%0d: seg=%b, required %b", d, seg, want_hex[d]);
                end
            end
        end
        hex_mode = 1'b0;
        wait_frame();
        repeat (16) begin
            @(negedge clk);
            d = lit_digit(an);
            if (d >= 0) begin
                checks++;
                if (seg !== want_dec[d]) begin
                    errors++;
                    $display("FAIL dec_mode digit%0d: seg=%b, required %b", d, seg, want_dec[d]);
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [6:0] want_a [4] = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
        logic       dp_a   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [6:0] want_b [4] = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        int d;
        lz_blank = 1'b1;
        value = 16'h0050; dp = 4'b1001; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame();
        repeat (16) begin
            @(negedge clk);
            d = lit_digit(an);
            if (d >= 0) begin
                checks++;
                if (seg !== want_a[d] || seg_dp !== dp_a[d]) begin
                    errors++;
                    $display("FAIL lz_0050 digit%0d: seg=%b dp=%b, required seg=%b dp=%b",
                             d, seg, seg_dp, want_a[d], dp_a[d]);
                end
            end
        end
        value = 16'h0000; dp = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame();
        repeat (16) begin
            @(negedge clk);
            d = lit_digit(an);
            if (d >= 0) begin
                checks++;
                if (seg !== want_b[d] || seg_dp !== 1'b1) begin
                    errors++;
                    $display("FAIL lz_0000 digit%0d: seg=%b dp=%b, required seg=%b dp=1", d, seg, seg_dp, want_b[d]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] want;
        lz_blank = 1'b0;
        wait_frame();
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            want = (c <= 16) ? 7'b1000000 : 7'b0100100;
            checks++;
            if ((lit_digit(an) >= 0 && seg !== want) || frame_done !== (c == 16 || c == 32)) begin
                errors++;
                $display("FAIL tear_free c=%0d: seg=%b an=%b fd=%b, required seg=%b when lit, fd=%0d",
                         c, seg, an, frame_done, want, c == 16 || c == 32);
            end
            if (c == 4)  begin value = 16'h1111; load = 1'b1; end
            if (c == 5)  load = 1'b0;
            if (c == 9)  begin value = 16'h2222; load = 1'b1; end
            if (c == 10) load = 1'b0;
        end
    endtask

    task automatic test_boundary_load();
        logic [6:0] want;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            want = (c <= 16) ? 7'b0100100 : 7'b1111000;
            checks++;
            if ((lit_digit(an) >= 0 && seg !== want) || frame_done !== (c == 16 || c == 32)) begin
                errors++;
                $display("FAIL boundary_load c=%0d: seg=%b an=%b fd=%b, required seg=%b when lit, fd=%0d",
                         c, seg, an, frame_done, want, c == 16 || c == 32);
            end
            if (c == 15) begin value = 16'h7777; load = 1'b1; end
            if (c == 16) load = 1'b0;
        end
    endtask

    task automatic test_midframe_reset();
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            if (c == 10 || c == 11) begin
                checks++;
                if (seg !== 7'b1111111 || seg_dp !== 1'b1 || an !== 4'b1111 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset_off c=%0d: seg=%b dp=%b an=%b fd=%b, required 1111111 1 1111 0",
                             c, seg, seg_dp, an, frame_done);
                end
            end
            if (c == 12) begin
                checks++;
                if (an !== 4'b1110 || seg !== 7'b1000000) begin
                    errors++;
                    $display("FAIL mid_reset_restart: an=%b seg=%b, required an=1110 seg=1000000", an, seg);
                end
            end
            if (c > 12) begin
                checks++;
                if ((lit_digit(an) >= 0 && seg !== 7'b1000000) || frame_done !== (c == 26 || c == 42)) begin
                    errors++;
                    $display("FAIL mid_reset_after c=%0d: seg=%b an=%b fd=%b, required seg=1000000 when lit, fd=%0d",
                             c, seg, an, frame_done, c == 26 || c == 42);
                end
            end
            if (c == 5)  begin value = 16'h3333; load = 1'b1; end
            if (c == 6)  load = 1'b0;
            if (c == 9)  rst = 1'b1;
            if (c == 10) rst = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            checks++;
            if ({seg, seg_dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
                errors++;
                $display("FAIL random c=%0d: seg=%b dp=%b an=%b fd=%b, required seg=%b dp=%b an=%b fd=%b",
                         c, seg, seg_dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
            end
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp    = 4'($urandom);
            if ($urandom_range(0, 31) == 0) hex_mode = ~hex_mode;
            if ($urandom_range(0, 31) == 0) lz_blank = ~lz_blank;
            rst   = ($urandom_range(0, 299) == 0);
        end
        load = 1'b0;
        rst  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_hex_vs_decimal();
        test_blanking();
        test_back_to_back();
        test_boundary_load();
        test_midframe_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
